// File: rtl/log_pkg.sv
// Shared constants and elaboration helpers for the mel log compressor.
//   LN2_Q16    : ln(2) in Q0.16, used to turn a log2 value into a natural log
//   chan_w     : width of a channel index for a given channel count
//   lut_entry  : round(log2(1 + k/2^addr_bits) * 2^frac), integer-only so it
//                can be evaluated at elaboration to fill a constant ROM
//   sat_int    : clamp a value to the signed range of a given bit width
package log_pkg;

    localparam int LN2_Q16 = 45426;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Binary log by repeated squaring in Q2.30: each squaring of y in [1,2)
    // yields one fractional bit of log2(y). Four guard bits are produced
    // beyond the requested precision and then rounded away.
    function automatic int lut_entry(input int k, input int addr_bits, input int frac);
        longint one_q;
        longint y;
        longint acc;
        one_q = longint'(1) <<< 30;
        y     = one_q + ((longint'(k) <<< 30) >>> addr_bits);
        acc   = 0;
        for (int i = 0; i < frac + 4; i++) begin
            y   = (y * y) >>> 30;
            acc = acc * 2;
            if (y >= 2 * one_q) begin
                acc = acc + 1;
                y   = y >>> 1;
            end
        end
        return int'((acc + 8) >>> 4);
    endfunction

    function automatic int sat_int(input int v, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/lod_norm.sv
// Leading-one detector and mantissa extractor (combinational).
//   x   : positive magnitude (sign bit already stripped by the caller)
//   msb : position of the leading one, 0..DATA_WIDTH-2 (0 when x is zero)
//   idx : the LUT_ADDR_BITS bits just below the leading one, i.e. the top
//         bits of x normalised so the leading one sits at the MSB; missing
//         bits below bit 0 read as zero
module lod_norm #(
    parameter int DATA_WIDTH    = 16,
    parameter int LUT_ADDR_BITS = 5
) (
    input  logic [DATA_WIDTH-2:0]       x,
    output logic [$clog2(DATA_WIDTH)-1:0] msb,
    output logic [LUT_ADDR_BITS-1:0]    idx
);
    localparam int MAG_W = DATA_WIDTH - 1;
    localparam int MSB_W = $clog2(DATA_WIDTH);

    logic [MSB_W-1:0] pos;

    always_comb begin
        msb = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (x[i]) msb = MSB_W'(i);
        end
        idx = '0;
        pos = '0;
        for (int j = 0; j < LUT_ADDR_BITS; j++) begin
            if (int'(msb) > j) begin
                pos = msb - MSB_W'(j + 1);
                idx[LUT_ADDR_BITS-1-j] = x[pos];
            end
        end
    end

endmodule

// File: rtl/log_compress_stream.sv
// Streaming log compressor for mel filterbank energies (one channel/cycle).
// Three pipeline stages:
//   S1 leading-one detect + mantissa index, S2 log2 = msb + LUT[index],
//   S3 optional ln scaling, round to output Q format, add offset, saturate.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ln_mode, log_offset per-beat mode and gain offset (travel with the beat)
//   in_data/in_valid/in_last/in_ready   input stream
//   out_data/out_chan/out_last/out_valid/out_ready   output stream
//   frame_err           sticky framing error, cleared only by rst
//
// Handshake: a beat transfers on any edge where valid && ready. The whole
// pipe advances when !out_valid || out_ready; in_ready is that same term,
// so every stage (and the output payload) holds while out_valid && !out_ready.
module log_compress_stream
    import log_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int LOG_WIDTH     = 8,
    parameter int LOG_FRAC      = 3,
    parameter int LUT_ADDR_BITS = 5,
    parameter int LUT_FRAC      = 8,
    parameter int NUM_FILTERS   = 26
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ln_mode,
    input  logic signed [LOG_WIDTH-1:0]    log_offset,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic signed [LOG_WIDTH-1:0]    out_data,
    output logic [$clog2(NUM_FILTERS)-1:0] out_chan,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_err
);
    localparam int MSB_W     = $clog2(DATA_WIDTH);
    localparam int CHAN_W    = chan_w(NUM_FILTERS);
    localparam int LUT_DEPTH = 1 << LUT_ADDR_BITS;
    localparam int LUT_W     = LUT_FRAC + 1;
    localparam int L_W       = MSB_W + LUT_FRAC + 1;
    localparam int R_W       = L_W + 1;
    localparam int MUL_W     = L_W + 17;
    localparam int SHIFT     = LUT_FRAC - LOG_FRAC;
    localparam int RND       = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
    localparam logic signed [LOG_WIDTH-1:0] FLOOR = {1'b1, {(LOG_WIDTH-1){1'b0}}};

    // Constant mantissa ROM, filled at elaboration.
    logic [LUT_W-1:0] lut_rom [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam int ENTRY = lut_entry(k, LUT_ADDR_BITS, LUT_FRAC);
        assign lut_rom[k] = LUT_W'(ENTRY);
    end

    logic advance;
    logic accept;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // S1 combinational
    logic [MSB_W-1:0]         lod_msb;
    logic [LUT_ADDR_BITS-1:0] lod_idx;
    logic                     in_floor;

    lod_norm #(
        .DATA_WIDTH    (DATA_WIDTH),
        .LUT_ADDR_BITS (LUT_ADDR_BITS)
    ) u_lod (
        .x   (in_data[DATA_WIDTH-2:0]),
        .msb (lod_msb),
        .idx (lod_idx)
    );

    // Non-positive energies have no log; they map to the floor code.
    assign in_floor = in_data[DATA_WIDTH-1] || (in_data == '0);

    // Channel tracking
    logic [CHAN_W-1:0] chan_cnt;
    logic              cnt_at_end;
    assign cnt_at_end = (chan_cnt == CHAN_W'(NUM_FILTERS - 1));

    // Stage registers
    logic                        s1_valid, s1_floor, s1_ln, s1_last;
    logic [MSB_W-1:0]            s1_msb;
    logic [LUT_ADDR_BITS-1:0]    s1_idx;
    logic signed [LOG_WIDTH-1:0] s1_off;
    logic [CHAN_W-1:0]           s1_chan;

    logic                        s2_valid, s2_floor, s2_ln, s2_last;
    logic [L_W-1:0]              s2_l;
    logic signed [LOG_WIDTH-1:0] s2_off;
    logic [CHAN_W-1:0]           s2_chan;

    // S2 combinational: integer part from msb, fraction from the ROM.
    logic [L_W-1:0] s1_l_next;
    assign s1_l_next = (L_W'(s1_msb) << LUT_FRAC) + L_W'(lut_rom[s1_idx]);

    // S3 combinational
    logic [MUL_W-1:0]            ln_prod;
    logic [L_W-1:0]              l_sel;
    logic [R_W-1:0]              r_sum;
    logic [L_W-1:0]              r_val;
    int                          biased;
    logic signed [LOG_WIDTH-1:0] s3_data;

    always_comb begin
        ln_prod = MUL_W'(s2_l) * MUL_W'(LN2_Q16) + MUL_W'(1 << 15);
        l_sel   = s2_ln ? L_W'(ln_prod >> 16) : s2_l;
        r_sum   = R_W'(l_sel) + R_W'(RND);
        r_val   = L_W'(r_sum >> SHIFT);
        biased  = int'(r_val) + int'(s2_off);
        s3_data = s2_floor ? FLOOR : LOG_WIDTH'(sat_int(biased, LOG_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_cnt  <= '0;
            frame_err <= 1'b0;
            s1_valid  <= 1'b0;
            s1_floor  <= 1'b0;
            s1_ln     <= 1'b0;
            s1_last   <= 1'b0;
            s1_msb    <= '0;
            s1_idx    <= '0;
            s1_off    <= '0;
            s1_chan   <= '0;
            s2_valid  <= 1'b0;
            s2_floor  <= 1'b0;
            s2_ln     <= 1'b0;
            s2_last   <= 1'b0;
            s2_l      <= '0;
            s2_off    <= '0;
            s2_chan   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                // Resync to channel 0 on either frame end marker, and flag
                // any disagreement between in_last and the channel count.
                chan_cnt <= (in_last || cnt_at_end) ? '0 : chan_cnt + CHAN_W'(1);
                if (in_last != cnt_at_end) frame_err <= 1'b1;
            end
            if (advance) begin
                s1_valid <= in_valid;
                s1_floor <= in_floor;
                s1_ln    <= ln_mode;
                s1_last  <= in_last;
                s1_msb   <= lod_msb;
                s1_idx   <= lod_idx;
                s1_off   <= log_offset;
                s1_chan  <= chan_cnt;

                s2_valid <= s1_valid;
                s2_floor <= s1_floor;
                s2_ln    <= s1_ln;
                s2_last  <= s1_last;
                s2_l     <= s1_l_next;
                s2_off   <= s1_off;
                s2_chan  <= s1_chan;

                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_data <= s3_data;
                    out_chan <= s2_chan;
                    out_last <= s2_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_log_compress_stream.sv
module tb_log_compress_stream;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int NF = 26;
    localparam int CW = $clog2(NF);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ln_mode;
    logic signed [LW-1:0] log_offset;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic signed [LW-1:0] out_data;
    logic [CW-1:0]        out_chan;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;

    int checks = 0;
    int errors = 0;

    log_compress_stream dut (
        .clk        (clk),
        .rst        (rst),
        .ln_mode    (ln_mode),
        .log_offset (log_offset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int data;
        int chan;
        int last;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   mchan = 0;
    int   drv_exp = 0;
    bit   lat_chk = 0;
    bit   rdy_mode = 0;
    bit   hold_pending = 0;
    int   held_data, held_chan, held_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: log2 via floor(log2(d)) plus a real-valued mantissa table.
    function automatic int model(input int d, input bit ln, input int off);
        int msb, idx, l, r, v;
        if (d <= 0) return -128;
        msb = 0;
        for (int i = 0; i < 15; i++) if (d >= (1 << i)) msb = i;
        if (msb >= 5) idx = (d >> (msb - 5)) & 31;
        else          idx = (d << (5 - msb)) & 31;
        l = msb * 256 + $rtoi($ln(1.0 + real'(idx) / 32.0) / $ln(2.0) * 256.0 + 0.5);
        if (ln) l = (l * 45426 + 32768) >>> 16;
        r = (l + 16) >>> 5;
        v = r + off;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // ---------------- downstream ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        cyc++;
        if (!rst) begin
            if (out_valid) begin
                if (hold_pending) begin
                    chk("hold_data", int'(out_data), held_data);
                    chk("hold_chan", int'(out_chan), held_chan);
                    chk("hold_last", int'(out_last), held_last);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d chan %0d, expected none", out_data, out_chan);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_chan", int'(out_chan), e.chan);
                        chk("out_last", int'(out_last), e.last);
                        if (lat_chk) chk("latency", cyc - e.acc, 3);
                    end
                    hold_pending = 0;
                end else begin
                    hold_pending = 1;
                    held_data = int'(out_data);
                    held_chan = int'(out_chan);
                    held_last = int'(out_last);
                end
            end else if (hold_pending) begin
                checks++;
                errors++;
                $display("FAIL dropped_beat: got out_valid 0 expected 1 while stalled");
                hold_pending = 0;
            end
            if (in_valid && in_ready) begin
                n.data = drv_exp;
                n.chan = mchan;
                n.last = int'(in_last);
                n.acc  = cyc;
                exp_q.push_back(n);
                mchan = (in_last || mchan == NF - 1) ? 0 : mchan + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int d, input bit ln, input int off, input bit last, input int exp);
        int guard;
        bit ok;
        in_data    = DW'(d);
        ln_mode    = ln;
        log_offset = LW'(off);
        in_last    = last;
        in_valid   = 1'b1;
        drv_exp    = exp;
        guard = 0;
        ok    = 0;
        while (!ok && guard < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 500 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input int last_at);
        int d, off;
        bit ln;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) d = -int'($urandom_range(0, 100));
            else                            d = int'($urandom_range(1, 32767));
            ln  = 1'($urandom_range(0, 1));
            off = int'($urandom_range(0, 40)) - 20;
            send_beat(d, ln, off, i == last_at, model(d, ln, off));
        end
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        exp_q.delete();
        hold_pending = 0;
        mchan = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int d;
        int ln;
        int off;
        int exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1,      0, 0,    0};
        vecs[1]  = '{256,    0, 0,    64};
        vecs[2]  = '{32767,  0, 0,    120};
        vecs[3]  = '{0,      0, 20,   -128};
        vecs[4]  = '{-5,     0, 20,   -128};
        vecs[5]  = '{32767,  0, 10,   127};
        vecs[6]  = '{1,      0, -128, -128};
        vecs[7]  = '{256,    1, 0,    44};
        vecs[8]  = '{256,    0, 0,    64};
        vecs[9]  = '{3,      0, 0,    13};
        vecs[10] = '{1024,   1, 0,    55};
        vecs[11] = '{16384,  0, -50,  62};
        vecs[12] = '{-32768, 0, 0,    -128};
        vecs[13] = '{1,      1, -3,   -3};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        ln_mode    = 1'b0;
        log_offset = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_chan",  int'(out_chan), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, back-to-back, out_ready held high, latency checked
        lat_chk = 1;
        for (int i = 0; i < 14; i++) begin
            send_beat(vecs[i].d, 1'(vecs[i].ln), vecs[i].off, 1'b0, vecs[i].exp);
        end
        idle();
        drain();
        lat_chk = 0;
        chk("table_frame_err", int'(frame_err), 0);
        do_reset();

        // Full frame with random backpressure
        rdy_mode = 1;
        send_frame(NF, NF - 1);
        drain();
        chk("good_frame_err", int'(frame_err), 0);

        // Short frame (in_last on channel 10), then a full frame
        send_frame(11, 10);
        drain();
        chk("short_frame_err", int'(frame_err), 1);
        send_frame(NF, NF - 1);
        drain();
        chk("sticky_frame_err", int'(frame_err), 1);

        // Reset in the middle of a frame with beats in flight
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_frame(8, -1);
        rst = 1'b1;
        idle();
        exp_q.delete();
        hold_pending = 0;
        mchan = 0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_in_ready",  int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_frame(NF, NF - 1);
        drain();
        chk("post_rst_frame_err", int'(frame_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
